// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Two WIDTH-bit operands are captured
// on an accepted start and shifted LSB-first through a 1-bit full subtractor
// with a registered borrow. The difference is assembled MSB-in in a
// right-shifting result register.
//
// Handshake: start is sampled only in IDLE. busy is high while shifting, and
// done pulses for exactly one cycle when Diff/Bout hold the finished result.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the ovf output, which
// reports signed overflow of the subtraction.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   operation request (IDLE only)
//   DATAa  in   minuend, WIDTH bits
//   DATAb  in   subtrahend, WIDTH bits
//   busy   out  high while in SHIFT
//   done   out  one-cycle result-valid pulse
//   Diff   out  DATAa - DATAb mod 2^WIDTH
//   Bout   out  final borrow (DATAa < DATAb unsigned)
//   ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] DATAa,
    input  logic [WIDTH-1:0] DATAb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             capture;
    logic             shift_en;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             brw_next;
    logic             last_shift;

    // 1-bit full subtractor on the current LSBs.
    assign a_bit      = a_reg[0];
    assign b_bit      = b_reg[0];
    assign d_bit      = a_bit ^ b_bit ^ brw;
    assign brw_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    assign last_shift = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        capture    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            Diff  <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (capture) begin
            a_reg <= DATAa;
            b_reg <= DATAb;
            brw   <= 1'b0;
            cnt   <= '0;
        end else if (shift_en) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            Diff  <= {d_bit, Diff[WIDTH-1:1]};
            brw   <= brw_next;
            cnt   <= cnt + CW'(1);
            if (last_shift) begin
                Bout <= brw_next;
`ifdef SERIAL_SUB_OVF_EN
                // On the last shift the LSBs are the operand sign bits.
                ovf  <= (a_bit != b_bit) && (d_bit != a_bit);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Drives a WIDTH=4 instance (index 0) and a WIDTH=8 instance (index 1) of
// serial_subtractor with directed vectors. A behavioural model tracks, per
// instance, how many cycles have passed since an accepted start and the
// arithmetic result, and a compare process checks busy/done every cycle and
// Diff/Bout whenever they must hold a finished result. Directed tasks also
// check literal expected values and done latency.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk;
    logic       rst [2];
    logic       st  [2];
    logic [7:0] da  [2];
    logic [7:0] db  [2];
    logic       bsy [2];
    logic       dn  [2];
    logic [7:0] df  [2];
    logic       bo  [2];
    logic       ov  [2];

    logic [3:0] diff4;
    logic [7:0] diff8;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;

    // Behavioural model state
    int m_cnt [2];
    int m_a   [2];
    int m_b   [2];
    int h_diff[2];
    int h_bout[2];
    int h_ovf [2];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (rst[0]),
        .start (st[0]),
        .DATAa (da[0][3:0]),
        .DATAb (db[0][3:0]),
        .busy  (bsy[0]),
        .done  (dn[0]),
        .Diff  (diff4),
        .Bout  (bo[0])
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ov[0])
`endif
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (rst[1]),
        .start (st[1]),
        .DATAa (da[1]),
        .DATAb (db[1]),
        .busy  (bsy[1]),
        .done  (dn[1]),
        .Diff  (diff8),
        .Bout  (bo[1])
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ov[1])
`endif
    );

    assign df[0] = {4'b0000, diff4};
    assign df[1] = diff8;
`ifndef SERIAL_SUB_OVF_EN
    assign ov[0] = 1'b0;
    assign ov[1] = 1'b0;
`endif

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_cnt = -1 means idle; otherwise cycles since the accepted start edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int w;
            int sa;
            int sb;
            int r;
            w = (k == 0) ? 4 : 8;
            if (rst[k]) begin
                m_cnt[k]  = -1;
                h_diff[k] = 0;
                h_bout[k] = 0;
                h_ovf[k]  = 0;
            end else if (m_cnt[k] == -1) begin
                if (st[k]) begin
                    m_cnt[k] = 0;
                    m_a[k]   = int'(da[k]) & ((1 << w) - 1);
                    m_b[k]   = int'(db[k]) & ((1 << w) - 1);
                end
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == w) begin
                    h_diff[k] = (m_a[k] - m_b[k]) & ((1 << w) - 1);
                    h_bout[k] = (m_a[k] < m_b[k]) ? 1 : 0;
                    sa = (m_a[k] >= (1 << (w - 1))) ? m_a[k] - (1 << w) : m_a[k];
                    sb = (m_b[k] >= (1 << (w - 1))) ? m_b[k] - (1 << w) : m_b[k];
                    r  = sa - sb;
                    h_ovf[k] = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
                end else if (m_cnt[k] > w) begin
                    m_cnt[k] = -1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                int w;
                w = (k == 0) ? 4 : 8;
                chk($sformatf("busy[%0d]", k), int'(bsy[k]),
                    (m_cnt[k] >= 0 && m_cnt[k] < w) ? 1 : 0);
                chk($sformatf("done[%0d]", k), int'(dn[k]), (m_cnt[k] == w) ? 1 : 0);
                if (m_cnt[k] == -1 || m_cnt[k] == w) begin
                    chk($sformatf("diff[%0d]", k), int'(df[k]), h_diff[k]);
                    chk($sformatf("bout[%0d]", k), int'(bo[k]), h_bout[k]);
`ifdef SERIAL_SUB_OVF_EN
                    chk($sformatf("ovf[%0d]", k), int'(ov[k]), h_ovf[k]);
`endif
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Wait (bounded) for done on instance k, counting edges after edge 0.
    task automatic wait_done(input int k, output int n);
        n = 0;
        while (!dn[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One operation from IDLE with literal expectations.
    task automatic op(input int k, input int a, input int b,
                      input int ed, input int eb, input int eo);
        int n;
        int w;
        w = (k == 0) ? 4 : 8;
        @(negedge clk);
        da[k] = 8'(a);
        db[k] = 8'(b);
        st[k] = 1'b1;
        @(negedge clk);               // edge 0 has accepted the start
        st[k] = 1'b0;
        da[k] = 8'($urandom_range(0, 255));  // operands may change after capture
        db[k] = 8'($urandom_range(0, 255));
        wait_done(k, n);
        chk($sformatf("lat %0d-%0d", a, b), n, w);
        chk($sformatf("lit_diff %0d-%0d", a, b), int'(df[k]), ed);
        chk($sformatf("lit_bout %0d-%0d", a, b), int'(bo[k]), eb);
`ifdef SERIAL_SUB_OVF_EN
        chk($sformatf("lit_ovf %0d-%0d", a, b), int'(ov[k]), eo);
`else
        if (eo < 0) $display("unexpected ovf expectation");
`endif
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int last;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            st[k]  = 1'b0;
            da[k]  = '0;
            db[k]  = '0;
            m_cnt[k] = -1;
            h_diff[k] = 0;
            h_bout[k] = 0;
            h_ovf[k]  = 0;
        end
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_done", int'(dn[0]), 0);
        chk("rst_diff", int'(df[0]), 0);
        chk("rst_bout", int'(bo[0]), 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        checking = 1;
        @(negedge clk);

        // WIDTH=4 directed vectors
        op(0, 9, 3, 6, 0, 1);
        op(0, 3, 9, 10, 1, 1);
        op(0, 0, 0, 0, 0, 0);
        op(0, 15, 15, 0, 0, 0);
        op(0, 0, 1, 15, 1, 0);
        op(0, 8, 1, 7, 0, 1);
        op(0, 5, 3, 2, 0, 0);
        op(0, 7, 15, 8, 1, 1);

        // start during SHIFT and DONE is ignored
        @(negedge clk);
        da[0] = 8'd9;
        db[0] = 8'd3;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        da[0] = 8'd1;
        db[0] = 8'd1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_done(0, n);
        chk("ign_lat", n, 2);          // two more edges after the ignored pulse
        chk("ign_diff", int'(df[0]), 6);
        st[0] = 1'b1;                  // sampled at the DONE->IDLE edge: ignored
        @(negedge clk);
        st[0] = 1'b0;
        chk("ign_done_busy", int'(bsy[0]), 0);
        repeat (3) @(negedge clk);
        chk("hold_diff", int'(df[0]), 6);

        // reset at the 2nd shift edge
        da[0] = 8'd9;
        db[0] = 8'd4;
        st[0] = 1'b1;
        @(negedge clk);                // after edge 0
        st[0] = 1'b0;
        @(negedge clk);                // after shift edge 1
        rst[0] = 1'b1;
        @(negedge clk);                // after shift edge 2 (reset)
        rst[0] = 1'b0;
        chk("mid_rst_busy", int'(bsy[0]), 0);
        chk("mid_rst_done", int'(dn[0]), 0);
        chk("mid_rst_diff", int'(df[0]), 0);
        chk("mid_rst_bout", int'(bo[0]), 0);
        op(0, 7, 2, 5, 0, 0);

        // WIDTH=8
        op(1, 8'h10, 8'h01, 8'h0F, 0, 0);
        op(1, 8'h01, 8'h80, 8'h81, 1, 1);

        // back-to-back with start held high
        @(negedge clk);
        da[1] = 8'h10;
        db[1] = 8'h01;
        st[1] = 1'b1;
        last = -1;
        n = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (dn[1]) begin
                if (last >= 0) chk("b2b_period", c - last, 10);
                last = c;
                n++;
            end
        end
        chk("b2b_pulses", n, 3);
        st[1] = 1'b0;                  // next edge is DONE->IDLE, so no new start
        repeat (3) @(negedge clk);
        chk("b2b_idle", int'(bsy[1]), 0);

        repeat (2) @(negedge clk);
        checking = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
